// File: rtl/mc_alu_if.sv
// Operand/result bundle between the datapath and the multi-cycle ALU.
interface mc_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [3:0]       alucontrol;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic             ready;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             illegal;

    // Datapath side: presents operations, consumes results and stall.
    modport master (
        output in_valid, alucontrol, sign, a, b, shamt,
        input  ready, busy, out_valid, result, hi, zero, illegal
    );

    // ALU side.
    modport slave (
        input  in_valid, alucontrol, sign, a, b, shamt,
        output ready, busy, out_valid, result, hi, zero, illegal
    );
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle MIPS ALU: registered single-cycle ops plus an iterative
// shift-add multiplier that holds the pipeline off via busy.
module mc_alu #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    mc_alu_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;
    localparam int         CW     = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1111;

    logic [0:0]         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplr;
    logic               psign;

    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   hi_r;
    logic               zero_r;
    logic               illegal_r;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ill;
    logic               lt;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic               last;

    assign bus.ready     = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.hi        = hi_r;
    assign bus.zero      = zero_r;
    assign bus.illegal   = illegal_r;

    // Single-cycle op decode; unsupported codes yield 0 and flag illegal.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        lt      = bus.sign ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
        case (bus.alucontrol)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_SLL:  alu_res = bus.b << bus.shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Multiplier operand magnitudes and the per-iteration accumulate step;
    // the final negation is folded into the step that completes the product.
    always_comb begin
        a_mag   = (bus.sign && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
        b_mag   = (bus.sign && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
        acc_nxt = acc + (mplr[0] ? mcand : '0);
        prod    = psign ? (~acc_nxt + 1'b1) : acc_nxt;
        last    = (count == CW'(WIDTH - 1));
    end

    // Control FSM, result registers and shift-add datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplr        <= '0;
            psign       <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            hi_r        <= '0;
            zero_r      <= 1'b1;
            illegal_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.alucontrol == OP_MUL) begin
                            state <= S_MUL;
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                            mplr  <= b_mag;
                            psign <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            acc   <= '0;
                            count <= '0;
                        end else begin
                            result_r    <= alu_res;
                            hi_r        <= '0;
                            zero_r      <= (alu_res == '0);
                            illegal_r   <= alu_ill;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + CW'(1);
                    if (last) begin
                        result_r    <= prod[WIDTH-1:0];
                        hi_r        <= prod[2*WIDTH-1:WIDTH];
                        zero_r      <= (prod[WIDTH-1:0] == '0);
                        illegal_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_alu.sv
// Randomized self-checking bench for mc_alu against an arithmetic reference.
module tb_mc_alu;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mc_alu_if #(.WIDTH(32)) bus ();

    mc_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report on mismatch.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference for single-cycle ops: {illegal, result}.
    function automatic logic [32:0] ref_op(input logic [3:0] op, input logic sg,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh);
        case (op)
            4'b0000: return {1'b0, a & b};
            4'b0001: return {1'b0, a | b};
            4'b0010: return {1'b0, a + b};
            4'b0110: return {1'b0, a - b};
            4'b0011: return {1'b0, b << sh};
            4'b0111: return {1'b0, 31'd0, sg ? ($signed(a) < $signed(b)) : (a < b)};
            4'b1100: return {1'b0, ~(a | b)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Reference product as a 64-bit integer multiply.
    function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Present a single-cycle op for one edge, then check its result.
    task automatic do_single(input string tag, input logic [3:0] op, input logic sg,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        logic [32:0] e;
        e = ref_op(op, sg, a, b, sh);
        bus.in_valid = 1'b1; bus.alucontrol = op; bus.sign = sg;
        bus.a = a; bus.b = b; bus.shamt = sh;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_ov"},   64'(bus.out_valid), 64'd1);
        chk({tag, "_res"},  64'(bus.result),    64'(e[31:0]));
        chk({tag, "_hi"},   64'(bus.hi),        64'd0);
        chk({tag, "_zero"}, 64'(bus.zero),      64'(e[31:0] == 32'd0));
        chk({tag, "_ill"},  64'(bus.illegal),   64'(e[32]));
        chk({tag, "_busy"}, 64'(bus.busy),      64'd0);
    endtask

    // Run a MUL; optionally keep hammering ADDs while busy (must be ignored).
    task automatic do_mul(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [63:0] e;
        logic [31:0] held;
        int lat, nbusy;
        e = ref_mul(sg, a, b);
        held = bus.result;
        bus.in_valid = 1'b1; bus.alucontrol = 4'hF; bus.sign = sg; bus.a = a; bus.b = b;
        @(negedge clk);
        chk({tag, "_acc_ready"}, 64'(bus.ready), 64'd0);
        nbusy = bus.busy ? 1 : 0;
        if (poke) begin
            bus.alucontrol = 4'b0010; bus.a = $urandom; bus.b = $urandom;
        end else begin
            bus.in_valid = 1'b0;
        end
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 16) chk({tag, "_hold"}, 64'(bus.result), 64'(held));
            if (bus.out_valid) begin
                lat = k;
                bus.in_valid = 1'b0;
            end else if (bus.busy) begin
                nbusy++;
            end
        end
        bus.in_valid = 1'b0;
        chk({tag, "_lat"},  64'(lat),          64'd32);
        chk({tag, "_busy"}, 64'(nbusy),        64'd32);
        chk({tag, "_lo"},   64'(bus.result),   64'(e[31:0]));
        chk({tag, "_hi"},   64'(bus.hi),       64'(e[63:32]));
        chk({tag, "_zero"}, 64'(bus.zero),     64'(e[31:0] == 32'd0));
        chk({tag, "_ill"},  64'(bus.illegal),  64'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rdy"},   64'(bus.ready),     64'd1);
    endtask

    initial begin
        int nov;
        logic [3:0] op;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.alucontrol = 4'b0010; bus.sign = 1'b0;
        bus.a = 32'd3; bus.b = 32'd4; bus.shamt = 5'd0;

        // Reset held for two edges with in_valid high: nothing accepted.
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 64'(bus.ready),     64'd1);
        chk("rst_busy",  64'(bus.busy),      64'd0);
        chk("rst_ov",    64'(bus.out_valid), 64'd0);
        chk("rst_res",   64'(bus.result),    64'd0);
        chk("rst_hi",    64'(bus.hi),        64'd0);
        chk("rst_zero",  64'(bus.zero),      64'd1);
        chk("rst_ill",   64'(bus.illegal),   64'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops.
        do_single("b2b_add", 4'b0010, 1'b0, 32'd7, 32'd5, 5'd0);
        do_single("b2b_sub", 4'b0110, 1'b0, 32'd5, 32'd5, 5'd0);
        do_single("b2b_sll", 4'b0011, 1'b0, 32'd0, 32'd1, 5'd31);
        chk("b2b_sll_val", 64'(bus.result), 64'h8000_0000);

        // SLT signedness.
        do_single("slt_s", 4'b0111, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("slt_s_val", 64'(bus.result), 64'd1);
        do_single("slt_u", 4'b0111, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("slt_u_val", 64'(bus.result), 64'd0);

        // Illegal code, then a legal op clears the flag.
        do_single("illegal", 4'b0101, 1'b0, 32'h1234, 32'h5678, 5'd3);
        do_single("ill_clr", 4'b0001, 1'b0, 32'h1234, 32'h5678, 5'd0);

        // Directed MULs.
        do_mul("mul_s", 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mul_s_val", {bus.hi, bus.result}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_mul("mul_u", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mul_u_val", {bus.hi, bus.result}, 64'h0000_0001_FFFF_FFFE);
        do_mul("mul_zero", 1'b1, 32'd0, 32'hDEAD_BEEF, 1'b0);
        do_mul("mul_poke", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // Reset pulse at iteration 10 of a MUL aborts it.
        bus.in_valid = 1'b1; bus.alucontrol = 4'hF; bus.sign = 1'b0;
        bus.a = 32'd9; bus.b = 32'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 9; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", 64'(bus.ready),     64'd1);
        chk("abort_ov",    64'(bus.out_valid), 64'd0);
        chk("abort_res",   64'(bus.result),    64'd0);
        chk("abort_zero",  64'(bus.zero),      64'd1);
        nov = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) nov++;
        end
        chk("abort_no_ov", 64'(nov), 64'd0);

        // Randomized single-cycle ops, mixing in illegal codes.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 14));
            do_single("rnd", op, 1'($urandom), $urandom, $urandom, 5'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Randomized MULs.
        for (int i = 0; i < 8; i++)
            do_mul("rnd_mul", 1'($urandom), $urandom, $urandom, 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
